// File: rtl/nmx1_wbm_pkg.sv
// nmx1_wbm_pkg: shared types and constants for the Neuromorphic X1 Wishbone master
package nmx1_wbm_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [31:0] TMO_DAT = 32'hDEAD_0000;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } cmd_t;

endpackage

// File: rtl/nmx1_wbm_fifo.sv
// nmx1_wbm_fifo: show-ahead synchronous command FIFO with full/empty and simultaneous push/pop
module nmx1_wbm_fifo
    import nmx1_wbm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  logic i_pop,
    input  cmd_t i_wdata,
    output cmd_t o_rdata,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    // A pop frees the head in the same cycle, so a push into a full FIFO is allowed alongside it
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_rdata = r_mem[r_rptr];

    // Storage has no reset; validity is tracked by the pointers and count
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/nmx1_wb_master.sv
// nmx1_wb_master: buffered Wishbone B4 classic initiator; optional ack timeout via NMX1_WBM_TIMEOUT_EN
module nmx1_wb_master
    import nmx1_wbm_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_we,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    state_t      r_state;
    state_t      w_next;
    cmd_t        w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_tmo;
    logic        w_done;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic [31:0] r_rsp_dat;
    logic        r_rsp_we;

    assign cmd_ready = !w_full && !wb_rst_i;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_done    = (r_state == REQ) && (wbm_ack_i || w_tmo);

    nmx1_wbm_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ('{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // cyc/stb decode straight from the state so an async reset drops them at once
    assign wbm_cyc_o = r_state == REQ;
    assign wbm_stb_o = r_state == REQ;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign rsp_valid = r_state == RESP;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_we    = r_rsp_we;

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Next state and FIFO pop; ack is only looked at while in REQ
    always_comb begin
        w_next = r_state;
        w_pop  = (r_state == IDLE) && !w_empty;
        case (r_state)
            IDLE:    w_next = w_empty ? IDLE : REQ;
            REQ:     w_next = (wbm_ack_i || w_tmo) ? RESP : REQ;
            RESP:    w_next = rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // Bus request registers load on pop; response registers load when the bus cycle ends
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_rsp_dat <= '0;
            r_rsp_we  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_we  <= w_head.we;
                r_adr <= w_head.adr;
                r_dat <= w_head.dat;
                r_sel <= w_head.sel;
            end
            if (w_done) begin
                r_rsp_we  <= r_we;
                r_rsp_dat <= !wbm_ack_i ? TMO_DAT : (r_we ? 32'h0 : wbm_dat_i);
            end
        end
    end

`ifdef NMX1_WBM_TIMEOUT_EN
    logic [31:0] r_tmo;
    logic        r_rsp_err;

    assign w_tmo   = (r_state == REQ) && !wbm_ack_i && (r_tmo == 32'(TIMEOUT_CYCLES - 1));
    assign rsp_err = r_rsp_err;

    // Count REQ cycles since the pop; the final REQ cycle without ack ends the bus cycle as an error
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_tmo     <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_pop) r_tmo <= '0;
            else if (r_state == REQ) r_tmo <= r_tmo + 1'b1;
            if (w_done) r_rsp_err <= w_tmo;
        end
    end
`else
    assign w_tmo   = 1'b0;
    assign rsp_err = 1'b0;
`endif

endmodule
